// File: rtl/pacman_pkg.sv
// Shared types and constants for the pacman collision/scoring logic.
package pacman_pkg;

  typedef enum logic [1:0] {NORMAL, FRIGHTENED, DYING, GAME_OVER} state_e;
  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, AQUA = 2'd2} ghost_e;

  localparam int NUM_GHOSTS        = 3;
  localparam int GHOST_BASE_POINTS = 200;
  localparam int COMBO_MAX         = 3;
  localparam int WARN_FRAMES       = 120;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ghost_collision_ctrl_sprite_overlap.sv
// Combinational bounding-box overlap test between two SIZE x SIZE sprites.
module sprite_overlap #(
  parameter int SIZE = 8
) (
  input  logic [9:0] aX,
  input  logic [9:0] aY,
  input  logic [9:0] bX,
  input  logic [9:0] bY,
  input  logic       mask,
  output logic       hit
);
  localparam logic [10:0] SZ = 11'(SIZE);

  logic [9:0] dx, dy;

  assign dx  = (aX >= bX) ? (aX - bX) : (bX - aX);
  assign dy  = (aY >= bY) ? (aY - bY) : (bY - aY);
  assign hit = !mask && ({1'b0, dx} < SZ) && ({1'b0, dy} < SZ);

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Per-frame pacman/ghost collision arbiter: death, ghost eating, fright timer,
// lives and game-over tracking. All outputs are registered.
import pacman_pkg::*;

module ghost_collision_ctrl #(
  parameter int SIZE          = 8,
  parameter int FRIGHT_FRAMES = 600,
  parameter int DEATH_FRAMES  = 120,
  parameter int LIVES_INIT    = 3
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [9:0]  pacmanX,
  input  logic [9:0]  pacmanY,
  input  logic [9:0]  ghost_redX,
  input  logic [9:0]  ghost_redY,
  input  logic [9:0]  ghost_greenX,
  input  logic [9:0]  ghost_greenY,
  input  logic [9:0]  ghost_aquaX,
  input  logic [9:0]  ghost_aquaY,
  input  logic        power_pellet,
  output logic        death,
  output logic        defeated_red,
  output logic        defeated_green,
  output logic        defeated_aqua,
  output logic        frightened,
  output logic        fright_warn,
  output logic [10:0] score_inc,
  output logic [1:0]  lives,
  output logic        respawn,
  output logic        game_over
);
  localparam int TW = $clog2(max2(FRIGHT_FRAMES, DEATH_FRAMES));
  localparam logic [TW-1:0] FR_LOAD = TW'(FRIGHT_FRAMES - 1);
  localparam logic [TW-1:0] DT_LOAD = TW'(DEATH_FRAMES - 1);
  localparam logic [TW-1:0] WARN_T  = TW'(WARN_FRAMES);

  state_e                         state_q, state_d;
  logic [TW-1:0]                  timer_q, timer_d;
  logic [1:0]                     combo_q, combo_d, combo_base;
  logic [1:0]                     lives_q, lives_d;
  logic [NUM_GHOSTS-1:0]          def_q, def_d, hit;
  logic [10:0]                    score_q, score_d;
  logic                           respawn_q, respawn_d;
  logic                           death_q, fright_q, warn_q, over_q;
  logic                           death_d, fright_d, warn_d, over_d;
  logic [NUM_GHOSTS-1:0][9:0]     gx, gy;

  assign gx = {ghost_aquaX, ghost_greenX, ghost_redX};
  assign gy = {ghost_aquaY, ghost_greenY, ghost_redY};

  // A ghost still showing its defeat pulse is masked until it warps home.
  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ovl
    sprite_overlap #(.SIZE(SIZE)) u_ovl (
      .aX(pacmanX), .aY(pacmanY), .bX(gx[g]), .bY(gy[g]),
      .mask(def_q[g]), .hit(hit[g])
    );
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    combo_d    = combo_q;
    lives_d    = lives_q;
    def_d      = '0;
    score_d    = '0;
    respawn_d  = 1'b0;
    combo_base = power_pellet ? 2'd0 : combo_q;
    unique case (state_q)
      NORMAL: begin
        if (power_pellet) begin
          state_d = FRIGHTENED;
          timer_d = FR_LOAD;
          combo_d = '0;
        end else if (|hit) begin
          state_d = DYING;
          timer_d = DT_LOAD;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end
      end
      FRIGHTENED: begin
        // A same-frame pellet clears the combo before the defeat is scored.
        if (|hit) begin
          if (hit[RED])        def_d[RED]   = 1'b1;
          else if (hit[GREEN]) def_d[GREEN] = 1'b1;
          else                 def_d[AQUA]  = 1'b1;
          score_d = 11'(GHOST_BASE_POINTS) << combo_base;
          combo_d = (combo_base == 2'(COMBO_MAX)) ? combo_base : combo_base + 2'd1;
        end else begin
          combo_d = combo_base;
        end
        if (power_pellet) begin
          timer_d = FR_LOAD;
        end else if (timer_q == '0) begin
          state_d = NORMAL;
          combo_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DYING: begin
        if (timer_q == '0) begin
          if (lives_q != 2'd0) begin
            state_d   = NORMAL;
            respawn_d = 1'b1;
          end else begin
            state_d = GAME_OVER;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAME_OVER: ;
    endcase
    death_d  = (state_d == DYING);
    fright_d = (state_d == FRIGHTENED);
    warn_d   = (state_d == FRIGHTENED) && (timer_d < WARN_T);
    over_d   = (state_d == GAME_OVER);
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= NORMAL;
      timer_q   <= '0;
      combo_q   <= '0;
      lives_q   <= 2'(LIVES_INIT);
      def_q     <= '0;
      score_q   <= '0;
      respawn_q <= 1'b0;
      death_q   <= 1'b0;
      fright_q  <= 1'b0;
      warn_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      combo_q   <= combo_d;
      lives_q   <= lives_d;
      def_q     <= def_d;
      score_q   <= score_d;
      respawn_q <= respawn_d;
      death_q   <= death_d;
      fright_q  <= fright_d;
      warn_q    <= warn_d;
      over_q    <= over_d;
    end
  end

  assign death          = death_q;
  assign defeated_red   = def_q[RED];
  assign defeated_green = def_q[GREEN];
  assign defeated_aqua  = def_q[AQUA];
  assign frightened     = fright_q;
  assign fright_warn    = warn_q;
  assign score_inc      = score_q;
  assign lives          = lives_q;
  assign respawn        = respawn_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Scoreboard bench: a frame-level game model predicts every registered output.
module tb_ghost_collision_ctrl;
  localparam int FRIGHT = 600;
  localparam int DEATHF = 120;
  localparam int SZ     = 8;

  logic        frame_clk = 1'b0;
  logic        Reset_n   = 1'b0;
  logic [9:0]  pacmanX = '0, pacmanY = '0;
  logic [9:0]  ghost_redX = '0, ghost_redY = '0;
  logic [9:0]  ghost_greenX = '0, ghost_greenY = '0;
  logic [9:0]  ghost_aquaX = '0, ghost_aquaY = '0;
  logic        power_pellet = 1'b0;
  logic        death, defeated_red, defeated_green, defeated_aqua;
  logic        frightened, fright_warn, respawn, game_over;
  logic [10:0] score_inc;
  logic [1:0]  lives;

  ghost_collision_ctrl dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n),
    .pacmanX(pacmanX), .pacmanY(pacmanY),
    .ghost_redX(ghost_redX), .ghost_redY(ghost_redY),
    .ghost_greenX(ghost_greenX), .ghost_greenY(ghost_greenY),
    .ghost_aquaX(ghost_aquaX), .ghost_aquaY(ghost_aquaY),
    .power_pellet(power_pellet),
    .death(death), .defeated_red(defeated_red), .defeated_green(defeated_green),
    .defeated_aqua(defeated_aqua), .frightened(frightened), .fright_warn(fright_warn),
    .score_inc(score_inc), .lives(lives), .respawn(respawn), .game_over(game_over)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    bit       death, fright, warn, over, resp;
    bit [2:0] def;
    int       score;
    int       lives;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Game model: 0 normal, 1 frightened, 2 dying, 3 game over.
  int       m_mode, m_fright_left, m_die_left, m_combo, m_lives;
  bit [2:0] m_prev_def;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fright_left = 0; m_die_left = 0; m_combo = 0; m_lives = 3;
    m_prev_def = '0;
  endtask

  task automatic frame(input int px, input int py, input int rx, input int ry,
                       input int gx, input int gy, input int ax, input int ay,
                       input bit pp);
    exp_t     e;
    int       xs[3];
    int       ys[3];
    bit [2:0] hit;
    int       c;
    @(negedge frame_clk);
    pacmanX = 10'(px); pacmanY = 10'(py);
    ghost_redX = 10'(rx); ghost_redY = 10'(ry);
    ghost_greenX = 10'(gx); ghost_greenY = 10'(gy);
    ghost_aquaX = 10'(ax); ghost_aquaY = 10'(ay);
    power_pellet = pp;
    xs = '{rx, gx, ax};
    ys = '{ry, gy, ay};
    for (int i = 0; i < 3; i++)
      hit[i] = !m_prev_def[i] && iabs(px - xs[i]) < SZ && iabs(py - ys[i]) < SZ;
    e = '{default: 0};
    case (m_mode)
      0: begin
        if (pp) begin
          m_mode = 1; m_fright_left = FRIGHT - 1; m_combo = 0;
        end else if (hit != 0) begin
          m_mode = 2; m_die_left = DEATHF - 1;
          if (m_lives > 0) m_lives--;
        end
      end
      1: begin
        c = pp ? 0 : m_combo;
        if (hit != 0) begin
          if (hit[0]) e.def[0] = 1'b1;
          else if (hit[1]) e.def[1] = 1'b1;
          else e.def[2] = 1'b1;
          e.score = 200 * (1 << c);
          if (c < 3) c++;
        end
        if (pp) m_fright_left = FRIGHT - 1;
        else if (m_fright_left == 0) begin m_mode = 0; c = 0; end
        else m_fright_left--;
        m_combo = c;
      end
      2: begin
        if (m_die_left == 0) begin
          if (m_lives > 0) begin m_mode = 0; e.resp = 1'b1; end
          else m_mode = 3;
        end else m_die_left--;
      end
      default: ;
    endcase
    e.death  = (m_mode == 2);
    e.fright = (m_mode == 1);
    e.warn   = (m_mode == 1) && (m_fright_left < 120);
    e.over   = (m_mode == 3);
    e.lives  = m_lives;
    m_prev_def = e.def;
    exp_q.push_back(e);
  endtask

  task automatic frame_far(input bit pp);
    frame(200, 200, 900, 50, 50, 900, 900, 900, pp);
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    pacmanX = 10'd200; pacmanY = 10'd200;
    ghost_redX = 10'd900; ghost_redY = 10'd50;
    ghost_greenX = 10'd50; ghost_greenY = 10'd900;
    ghost_aquaX = 10'd900; ghost_aquaY = 10'd900;
    power_pellet = 1'b0;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_lives", int'(lives), 3);
    check("rst_death", int'(death), 0);
    check("rst_frightened", int'(frightened), 0);
    check("rst_warn", int'(fright_warn), 0);
    check("rst_game_over", int'(game_over), 0);
    check("rst_respawn", int'(respawn), 0);
    check("rst_defeated", int'({defeated_aqua, defeated_green, defeated_red}), 0);
    check("rst_score", int'(score_inc), 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  // Monitor: one expectation per frame edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("death", int'(death), int'(e.death));
        check("frightened", int'(frightened), int'(e.fright));
        check("fright_warn", int'(fright_warn), int'(e.warn));
        check("game_over", int'(game_over), int'(e.over));
        check("respawn", int'(respawn), int'(e.resp));
        check("defeated", int'({defeated_aqua, defeated_green, defeated_red}), int'(e.def));
        check("score_inc", int'(score_inc), e.score);
        check("lives", int'(lives), e.lives);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int px, py;
    int pos[6];
    model_reset();
    do_reset();

    // Overlap boundary: dx=8 misses, dx=7 kills; then respawn.
    frame(200, 200, 208, 200, 50, 900, 900, 900, 1'b0);
    frame(200, 200, 207, 200, 50, 900, 900, 900, 1'b0);
    repeat (125) frame_far(1'b0);

    // Combo: each defeated ghost leaves before the next frame.
    frame_far(1'b1);
    frame(200, 200, 200, 200, 203, 205, 195, 193, 1'b0);
    frame(200, 200, 900, 50, 203, 205, 195, 193, 1'b0);
    frame(200, 200, 900, 50, 50, 900, 195, 193, 1'b0);
    repeat (610) frame_far(1'b0);

    // Pellet exactly on the expiry frame extends fright.
    frame_far(1'b1);
    repeat (FRIGHT - 1) frame_far(1'b0);
    frame_far(1'b1);
    repeat (605) frame_far(1'b0);

    // Remaining two lives, then game over; pellet and overlap ignored there.
    repeat (2) begin
      frame(200, 200, 204, 196, 50, 900, 900, 900, 1'b0);
      repeat (125) frame_far(1'b0);
    end
    frame_far(1'b1);
    frame(200, 200, 200, 200, 50, 900, 900, 900, 1'b0);
    repeat (5) frame_far(1'b0);

    // Reset mid-DYING.
    do_reset();
    frame(200, 200, 200, 200, 50, 900, 900, 900, 1'b0);
    repeat (50) frame_far(1'b0);
    do_reset();
    frame_far(1'b0);

    // Randomised play segments.
    repeat (3) begin
      do_reset();
      px = 100 + int'($urandom_range(0, 600));
      py = 100 + int'($urandom_range(0, 600));
      repeat (800) begin
        pos = '{900, 50, 50, 900, 900, 900};
        for (int g = 0; g < 3; g++)
          if ($urandom_range(0, 3) == 0) begin
            pos[2*g]   = px + int'($urandom_range(0, 20)) - 10;
            pos[2*g+1] = py + int'($urandom_range(0, 20)) - 10;
          end
        frame(px, py, pos[0], pos[1], pos[2], pos[3], pos[4], pos[5],
              $urandom_range(0, 39) == 0);
      end
    end

    @(posedge frame_clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
